// File: rtl/line_sequencer_pkg.sv
// Shared types and default geometry for the line sequencer front end.
package line_pkg;

  localparam int CW_DEF     = 11;
  localparam int WIDTH_DEF  = 640;
  localparam int HEIGHT_DEF = 480;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DRAW  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  typedef struct packed {
    logic              clear;
    logic              color;
    logic [CW_DEF-1:0] x0;
    logic [CW_DEF-1:0] y0;
    logic [CW_DEF-1:0] x1;
    logic [CW_DEF-1:0] y1;
  } line_cmd_t;

endpackage

// File: rtl/line_sequencer_rr_arb2.sv
// Two-requester round-robin arbiter: a tie goes to whoever was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/line_sequencer.sv
// Command front end: arbitrates two requesters, sequences the line engine,
// sweeps the framebuffer for clears, and drives the single pixel-write port.
module line_sequencer
  import line_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int CW     = CW_DEF,
  parameter int WDOG   = 2048
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [1:0]    req_clear,
  input  logic [1:0]    req_color,
  input  logic [2*CW-1:0] req_x0,
  input  logic [2*CW-1:0] req_y0,
  input  logic [2*CW-1:0] req_x1,
  input  logic [2*CW-1:0] req_y1,
  output logic [1:0]    cmd_done,
  output logic          eng_start,
  output logic [CW-1:0] eng_x0,
  output logic [CW-1:0] eng_y0,
  output logic [CW-1:0] eng_x1,
  output logic [CW-1:0] eng_y1,
  input  logic [CW-1:0] eng_x,
  input  logic [CW-1:0] eng_y,
  input  logic          eng_pix_valid,
  input  logic          eng_done,
  output logic          pix_we,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_color,
  output logic          busy,
  output logic          err
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_START = ST_START;
  localparam logic [2:0] S_DRAW  = ST_DRAW;
  localparam logic [2:0] S_CLEAR = ST_CLEAR;
  localparam logic [2:0] S_FIN   = ST_FIN;

  localparam int WDW = (WDOG > 2) ? $clog2(WDOG) : 1;

  logic [2:0]    state_q, state_d;
  line_cmd_t     cmd_q, cmd_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [CW-1:0] cx_q, cx_d;
  logic [CW-1:0] cy_q, cy_d;
  logic          err_q, err_d;

  logic [1:0]    gnt;
  logic [1:0]    accept;
  logic          sel;

  rr_arb2 u_arb (
    .req  (req_valid),
    .last (last_q),
    .gnt  (gnt)
  );

  assign req_ready = (state_q == S_IDLE) ? gnt : 2'b00;
  assign accept    = req_valid & req_ready;
  assign sel       = accept[1];

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = wd_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept != 2'b00) begin
          grant_d     = sel;
          cmd_d.clear = req_clear[sel];
          cmd_d.color = req_color[sel];
          cmd_d.x0    = CW_DEF'(sel ? req_x0[2*CW-1:CW] : req_x0[CW-1:0]);
          cmd_d.y0    = CW_DEF'(sel ? req_y0[2*CW-1:CW] : req_y0[CW-1:0]);
          cmd_d.x1    = CW_DEF'(sel ? req_x1[2*CW-1:CW] : req_x1[CW-1:0]);
          cmd_d.y1    = CW_DEF'(sel ? req_y1[2*CW-1:CW] : req_y1[CW-1:0]);
          cx_d        = '0;
          cy_d        = '0;
          state_d     = req_clear[sel] ? S_CLEAR : S_START;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        // wd_q == 0 marks the first DRAW cycle, where eng_done is still from the previous line
        wd_d = wd_q + WDW'(1);
        if (eng_done && (wd_q != '0)) begin
          state_d = S_FIN;
        end else if (wd_q == WDW'(WDOG - 1)) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_CLEAR: begin
        if (cx_q == CW'(WIDTH - 1)) begin
          cx_d = '0;
          if (cy_q == CW'(HEIGHT - 1)) state_d = S_FIN;
          else                         cy_d    = cy_q + CW'(1);
        end else begin
          cx_d = cx_q + CW'(1);
        end
      end
      S_FIN: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      wd_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      err_q   <= err_d;
    end
  end

  assign eng_start = (state_q == S_START);
  assign eng_x0    = CW'(cmd_q.x0);
  assign eng_y0    = CW'(cmd_q.y0);
  assign eng_x1    = CW'(cmd_q.x1);
  assign eng_y1    = CW'(cmd_q.y1);

  // Outputs decode straight from state so a synchronous reset silences the port at once
  always_comb begin
    pix_we    = 1'b0;
    pix_x     = '0;
    pix_y     = '0;
    pix_color = 1'b0;
    if (state_q == S_DRAW) begin
      pix_we    = eng_pix_valid;
      pix_x     = eng_x;
      pix_y     = eng_y;
      pix_color = cmd_q.color;
    end else if (state_q == S_CLEAR) begin
      pix_we    = 1'b1;
      pix_x     = cx_q;
      pix_y     = cy_q;
      pix_color = cmd_q.color;
    end
  end

  assign cmd_done = (state_q == S_FIN) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_line_sequencer.sv
// Self-checking bench for line_sequencer: a small screen and short watchdog so
// clears and aborts stay cheap; expectations come from a per-command timeline model.
module tb_line_sequencer;
  import line_pkg::*;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int WD  = 16;
  localparam int CWB = CW_DEF;
  localparam int RW  = 2 * CWB;

  logic           clk, reset;
  logic [1:0]     req_valid, req_ready, req_clear, req_color, cmd_done;
  logic [RW-1:0]  req_x0, req_y0, req_x1, req_y1;
  logic           eng_start, eng_pix_valid, eng_done, pix_we, pix_color, busy, err;
  logic [CWB-1:0] eng_x0, eng_y0, eng_x1, eng_y1, eng_x, eng_y, pix_x, pix_y;

  line_sequencer #(.WIDTH(W), .HEIGHT(H), .CW(CWB), .WDOG(WD)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_clear(req_clear), .req_color(req_color),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .cmd_done(cmd_done), .eng_start(eng_start),
    .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_x1(eng_x1), .eng_y1(eng_y1),
    .eng_x(eng_x), .eng_y(eng_y), .eng_pix_valid(eng_pix_valid), .eng_done(eng_done),
    .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCnt = 0;
  int passCnt  = 0;

  logic           chkEn = 1'b0;
  logic [1:0]     expReady, expDone;
  logic           expStart, expWe, expColor, expBusy, expErr;
  logic [CWB-1:0] expX, expY;
  logic [CWB-1:0] expE [4];

  int             lastM = 1;
  logic           errM  = 1'b0;
  logic [CWB-1:0] engM [4] = '{default: '0};

  int cyc = 0;
  int acceptCyc = 0;
  int doneCyc = 0;
  int doneLog[$];
  logic [CWB-1:0] wrX[$], wrY[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ((req_valid & req_ready) != 2'b00) acceptCyc = cyc;
    if (cmd_done != 2'b00) begin
      doneCyc = cyc;
      doneLog.push_back(cmd_done[1] ? 1 : 0);
    end
    if (pix_we === 1'b1) begin
      wrX.push_back(pix_x);
      wrY.push_back(pix_y);
    end
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    checkCnt++;
    if (act === req) passCnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic checkOutput();
    checkVal("req_ready", 32'(req_ready), 32'(expReady));
    checkVal("cmd_done", 32'(cmd_done), 32'(expDone));
    checkVal("eng_start", 32'(eng_start), 32'(expStart));
    checkVal("pix_we", 32'(pix_we), 32'(expWe));
    checkVal("busy", 32'(busy), 32'(expBusy));
    checkVal("err", 32'(err), 32'(expErr));
    checkVal("eng_x0", 32'(eng_x0), 32'(expE[0]));
    checkVal("eng_y0", 32'(eng_y0), 32'(expE[1]));
    checkVal("eng_x1", 32'(eng_x1), 32'(expE[2]));
    checkVal("eng_y1", 32'(eng_y1), 32'(expE[3]));
    if (expWe) begin
      checkVal("pix_x", 32'(pix_x), 32'(expX));
      checkVal("pix_y", 32'(pix_y), 32'(expY));
      checkVal("pix_color", 32'(pix_color), 32'(expColor));
    end
  endtask

  always @(negedge clk) if (chkEn) checkOutput();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdleExp();
    expReady = 2'b00;
    expDone  = 2'b00;
    expStart = 1'b0;
    expWe    = 1'b0;
    expBusy  = 1'b0;
    expColor = 1'b0;
    expX     = '0;
    expY     = '0;
    expErr   = errM;
    expE     = engM;
  endtask

  task automatic scrambleAll();
    req_x0    = RW'($urandom);
    req_y0    = RW'($urandom);
    req_x1    = RW'($urandom);
    req_y1    = RW'($urandom);
    req_color = 2'($urandom_range(3));
  endtask

  task automatic randEngine();
    eng_x         = CWB'($urandom);
    eng_y         = CWB'($urandom);
    eng_pix_valid = 1'($urandom_range(1));
  endtask

  task automatic doReset();
    chkEn = 1'b0;
    reset = 1'b1;
    req_valid = 2'b00;
    eng_done = 1'b0;
    eng_pix_valid = 1'b0;
    tick();
    tick();
    errM  = 1'b0;
    lastM = 1;
    engM  = '{default: '0};
    setIdleExp();
    chkEn = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One arbitration cycle and, if something is accepted, the whole command.
  // dlen: DRAW index at which the engine raises done (0 = never); rstAt: DRAW index to reset on.
  task automatic applyStimulus(input int dlen, input bit stale, input int rstAt);
    int w;
    bit abort;
    line_cmd_t c;
    setIdleExp();
    randEngine();
    eng_done = stale;
    if (req_valid == 2'b11)  w = 1 - lastM;
    else if (req_valid[0])   w = 0;
    else if (req_valid[1])   w = 1;
    else                     w = -1;
    if (w >= 0) begin
      expReady = 2'(1 << w);
      c.clear  = req_clear[w];
      c.color  = req_color[w];
      c.x0     = req_x0[w*CWB +: CWB];
      c.y0     = req_y0[w*CWB +: CWB];
      c.x1     = req_x1[w*CWB +: CWB];
      c.y1     = req_y1[w*CWB +: CWB];
    end
    tick();
    if (w < 0) return;
    engM = '{c.x0, c.y0, c.x1, c.y1};
    scrambleAll();
    abort = 1'b0;
    if (c.clear) begin
      for (int k = 0; k < W * H; k++) begin
        setIdleExp();
        expBusy  = 1'b1;
        expWe    = 1'b1;
        expX     = CWB'(k % W);
        expY     = CWB'(k / W);
        expColor = c.color;
        randEngine();
        eng_done = 1'($urandom_range(1));
        tick();
        scrambleAll();
      end
    end else begin
      setIdleExp();
      expBusy  = 1'b1;
      expStart = 1'b1;
      randEngine();
      eng_done = stale;
      tick();
      scrambleAll();
      for (int j = 0; j < WD; j++) begin
        bit fin;
        setIdleExp();
        expBusy = 1'b1;
        randEngine();
        eng_done = (j == 0) ? stale : (dlen > 0 && j >= dlen);
        expWe    = eng_pix_valid;
        expX     = eng_x;
        expY     = eng_y;
        expColor = c.color;
        if (j == rstAt) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
          req_valid = 2'b00;
          eng_pix_valid = 1'b1;
          eng_done = 1'b1;
          errM  = 1'b0;
          lastM = 1;
          engM  = '{default: '0};
          setIdleExp();
          tick();
          return;
        end
        fin = (j > 0) && eng_done;
        if (!fin && j == WD - 1) abort = 1'b1;
        tick();
        scrambleAll();
        if (fin || abort) break;
      end
    end
    if (abort) errM = 1'b1;
    setIdleExp();
    expBusy = 1'b1;
    expDone = 2'(1 << w);
    randEngine();
    eng_done = 1'($urandom_range(1));
    tick();
    lastM = w;
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL timeout: time %0t, limit 500000", $time);
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int mark;
    reset = 1'b1;
    req_valid = 2'b00;
    req_clear = 2'b00;
    req_color = 2'b00;
    req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0;
    eng_x = '0; eng_y = '0; eng_pix_valid = 1'b0; eng_done = 1'b0;
    doReset();
    checkVal("rst pix_x", 32'(pix_x), 32'd0);
    checkVal("rst pix_y", 32'(pix_y), 32'd0);
    checkVal("rst pix_color", 32'(pix_color), 32'd0);

    // Single line from requester 0, colour 1, (10,20)->(15,20)
    req_valid = 2'b01;
    req_clear = 2'b00;
    req_color = 2'b01;
    req_x0 = RW'(10); req_y0 = RW'(20); req_x1 = RW'(15); req_y1 = RW'(20);
    applyStimulus(4, 1'b0, -1);
    req_valid = 2'b00;
    checkVal("lit eng_x0", 32'(eng_x0), 32'd10);
    checkVal("lit eng_y0", 32'(eng_y0), 32'd20);
    checkVal("lit eng_x1", 32'(eng_x1), 32'd15);
    checkVal("lit eng_y1", 32'(eng_y1), 32'd20);
    checkVal("lit line latency", 32'(doneCyc - acceptCyc), 32'd7);
    checkVal("lit single done count", 32'(doneLog.size()), 32'd1);
    applyStimulus(4, 1'b0, -1);

    // Contention from reset: both held valid
    doReset();
    mark = doneLog.size();
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) applyStimulus(2, 1'b0, -1);
    req_valid = 2'b00;
    checkVal("lit rr count", 32'(doneLog.size() - mark), 32'd4);
    for (int n = 0; n < 4; n++)
      if (mark + n < doneLog.size()) checkVal("lit rr order", 32'(doneLog[mark + n]), 32'(n % 2));

    // Small clear from requester 1
    mark = wrX.size();
    req_valid = 2'b10;
    req_clear = 2'b10;
    req_color = 2'b10;
    applyStimulus(0, 1'b0, -1);
    req_valid = 2'b00;
    req_clear = 2'b00;
    checkVal("lit clear writes", 32'(wrX.size() - mark), 32'd12);
    if (wrX.size() >= mark + 12) begin
      checkVal("lit clear first x", 32'(wrX[mark]), 32'd0);
      checkVal("lit clear first y", 32'(wrY[mark]), 32'd0);
      checkVal("lit clear last x", 32'(wrX[mark + 11]), 32'd3);
      checkVal("lit clear last y", 32'(wrY[mark + 11]), 32'd2);
    end
    checkVal("lit clear done req", 32'(doneLog[$]), 32'd1);

    // Watchdog: engine never finishes
    req_valid = 2'b01;
    applyStimulus(0, 1'b0, -1);
    req_valid = 2'b00;
    checkVal("lit wdog latency", 32'(doneCyc - acceptCyc), 32'd18);
    checkVal("lit wdog err", 32'(err), 32'd1);

    // Stale done held high through START and the first DRAW cycle
    req_valid = 2'b10;
    applyStimulus(3, 1'b1, -1);
    req_valid = 2'b00;
    checkVal("lit stale latency", 32'(doneCyc - acceptCyc), 32'd6);
    checkVal("lit err sticky", 32'(err), 32'd1);

    // Reset on the third DRAW cycle, then a normal command
    mark = doneLog.size();
    req_valid = 2'b01;
    applyStimulus(8, 1'b0, 2);
    checkVal("lit reset no done", 32'(doneLog.size() - mark), 32'd0);
    checkVal("lit reset err", 32'(err), 32'd0);
    req_valid = 2'b10;
    applyStimulus(2, 1'b0, -1);
    req_valid = 2'b00;
    checkVal("lit post-reset done", 32'(doneLog.size() - mark), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      req_valid = 2'($urandom_range(3));
      req_clear = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
      applyStimulus(($urandom_range(7) == 0) ? 0 : int'($urandom_range(10, 1)),
                    1'($urandom_range(1)), -1);
    end
    req_valid = 2'b00;
    applyStimulus(0, 1'b0, -1);

    chkEn = 1'b0;
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/line_sequencer.md
# line_sequencer

Two-port command front end for the line-drawing engine. It arbitrates line and clear-screen commands from two requesters, such as user input and an animation FSM, using round-robin. It sequences the engine through start and done for each line, and it sweeps the framebuffer itself for clear commands. All pixel writes leave through a single pixel-write port to the VGA framebuffer.

## Interface
Parameters:
- WIDTH, 640: screen width in pixels
- HEIGHT, 480: screen height in pixels
- CW, 11: coordinate width
- WDOG, 2048: max cycles allowed in DRAW before abort

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- req_valid  in  2  per-requester command valid
- req_ready  out  2  per-requester accept; at most one bit high
- req_clear  in  2  1 = clear-screen command; coordinates are ignored
- req_color  in  2  pixel colour for the command
- req_x0, req_y0, req_x1, req_y1  in  2xCW each  endpoints per requester
- cmd_done  out  2  one-cycle pulse to the requester whose command finished
- eng_start  out  1  one-cycle pulse; the engine restarts from the eng_* coordinates
- eng_x0, eng_y0, eng_x1, eng_y1  out  CW each  latched endpoints, stable from START until the next accept
- eng_x, eng_y  in  CW each  engine pixel coordinate
- eng_pix_valid  in  1  engine pixel coordinate valid this cycle
- eng_done  in  1  engine level-done
- pix_we  out  1  framebuffer write strobe
- pix_x, pix_y  out  CW each  write address
- pix_color  out  1  write data
- busy  out  1  high in every state except IDLE
- err  out  1  sticky watchdog flag; cleared only by reset

## Operation
- The FSM has five states: IDLE, START, DRAW, CLEAR, FIN.
- **IDLE**
  - Grant goes to req_valid[i]. If both are valid, grant goes to the requester other than last_grant.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - req_ready[grant] is high combinationally in IDLE only. Accept = valid & ready.
  - On accept the block latches the coordinates, colour, clear flag and grant index.
  - It then moves to START, or to CLEAR if the clear flag is set.
- **START**
  - eng_start = 1 for exactly one cycle.
  - The watchdog counter is zeroed, then the FSM moves to DRAW.
- **DRAW**
  - pix_we = eng_pix_valid, with pix_x/pix_y taken from eng_x/eng_y and pix_color from the latched colour.
  - The watchdog increments every cycle.
  - If eng_done is high, go to FIN. eng_done is ignored in the first DRAW cycle, because the engine's done flag from the previous line is stale.
  - If the watchdog reaches WDOG−1 first, set err and go to FIN.
- **CLEAR**
  - Counters cx and cy start at 0. Each cycle: pix_we = 1, pix_x = cx, pix_y = cy.
  - cx increments and wraps at WIDTH−1 to 0. cy increments when cx wraps.
  - After pixel (WIDTH−1, HEIGHT−1), go to FIN.
- **FIN**
  - cmd_done[grant] = 1 for one cycle.
  - last_grant is set to grant, then the FSM returns to IDLE.
- Every coordinate path is CW bits unsigned.
- Clear-sweep counters never exceed WIDTH−1 or HEIGHT−1.

## Timing
- Reset state: IDLE. Every output is 0: req_ready, cmd_done, eng_start, pix_we, busy, err. All coordinates are 0.
- A reset in any state aborts the command with no cmd_done, drops pix_we in the same cycle it takes effect, and clears err.
- Line latency:
  - accept cycle (IDLE)
  - START at +1
  - first DRAW cycle at +2
  - pixels written while the engine is valid
  - FIN one cycle after eng_done is seen
  - back in IDLE the following cycle
- Clear latency: WIDTH·HEIGHT write cycles, then FIN, then IDLE.
- Back-to-back: a requester held valid is accepted again in the first IDLE cycle after FIN. This gives a minimum 2-cycle gap between commands.
- If the requester changes its inputs while not yet granted, the block uses the values present in the accept cycle.

## Structure
- Package line_pkg holds:
  - the state enum typedef
  - CW, WIDTH and HEIGHT default constants
  - a packed struct line_cmd_t {clear, color, x0, y0, x1, y1}
- Sub-module rr_arb2: a two-request round-robin arbiter with inputs req[1:0] and last and output gnt[1:0], one-hot or zero.
- The engine is instantiated beside this block at top level, not inside it.

## Test plan
- Single line: req0 sends (10,20)->(15,20), colour 1. Expect exactly one accept, eng_start one cycle later, pix_we on every eng_pix_valid cycle with pix_color = 1, then cmd_done[0] pulsing once.
- Contention: both requesters valid continuously with short lines. Expect grants in the order 0, 1, 0, 1, with req_ready never 2'b11.
- Clear, small: WIDTH = 4, HEIGHT = 3 with a req1 clear. Expect 12 consecutive pix_we cycles in order (0,0),(1,0)…(3,2), then cmd_done[1].
- Watchdog: model the engine so eng_done never rises, with WDOG = 16. Expect err set after 16 DRAW cycles, cmd_done still pulsing, and err holding until reset.
- Reset mid-line: assert reset on the third DRAW cycle. Next cycle: IDLE, all outputs 0, no cmd_done. A new command is then accepted normally.
- Stale done: eng_done is already high at START. Expect the block to stay in DRAW for at least one cycle and to write the engine's pixels from the new line.
